decoder8_pulse: RTL and testbench

DECODER8_PULSE -- requirements
Module: decoder8_pulse

---
 rtl/decoder8_pulse.sv | 158 +++++++++++++++
 tb/tb_decoder8_pulse.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder8_pulse.sv
// decoder8_pulse: accepts a 3-bit code and emits a registered one-hot pulse
// of HOLD cycles, followed by GAP forced-idle cycles.
// Optional build macro: DECODER8_QUEUE_EN adds a one-entry pending code slot
// so a code offered during a pulse or gap is chained straight into the next
// pulse without an IDLE cycle.
//
// Handshake: a code is taken on a rising edge where din_valid && din_ready.
// din_ready is combinational; din_valid/din are never required to be held.
module decoder8_pulse #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din_valid,
    input  logic [2:0] din,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam logic [7:0] HOLD_M1  = 8'(HOLD - 1);
    localparam logic [7:0] GAP_M1   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic       GAP_ZERO = (GAP == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] r_dout;
    logic [7:0] w_dout_nxt;
    logic       w_ready;
    logic       w_accept;
    logic       w_term;

`ifdef DECODER8_QUEUE_EN
    logic       r_pend_valid;
    logic       w_pend_valid_nxt;
    logic [2:0] r_pend_code;
    logic [2:0] w_pend_code_nxt;

    // Ready whenever the pending slot is free, in every state.
    assign w_ready = en & ~r_pend_valid;
`else
    // Ready only while idle; codes offered during a pulse or gap are dropped.
    assign w_ready = en & (r_state == S_IDLE);
`endif

    assign w_accept = din_valid & w_ready;

    // Terminal edge: last gap cycle, or last pulse cycle when there is no gap.
    assign w_term = (r_cnt == 8'd0) &
                    ((r_state == S_GAP) | ((r_state == S_PULSE) & GAP_ZERO));

    // Next-state, counter and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
`ifdef DECODER8_QUEUE_EN
        w_pend_valid_nxt = r_pend_valid;
        w_pend_code_nxt  = r_pend_code;
`endif
        case (r_state)
            S_IDLE: begin
                w_dout_nxt = 8'h00;
                if (w_accept) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = HOLD_M1;
                    w_dout_nxt  = 8'h01 << din;
                end
            end
            S_PULSE: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else if (!GAP_ZERO) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_M1;
                    w_dout_nxt  = 8'h00;
                end
            end
            S_GAP: begin
                w_dout_nxt = 8'h00;
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
                w_dout_nxt  = 8'h00;
            end
        endcase

        if (w_term) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
            w_dout_nxt  = 8'h00;
`ifdef DECODER8_QUEUE_EN
            // A stored code wins; otherwise a code offered on this edge
            // (pending empty) starts the next pulse directly.
            if (r_pend_valid) begin
                w_state_nxt      = S_PULSE;
                w_cnt_nxt        = HOLD_M1;
                w_dout_nxt       = 8'h01 << r_pend_code;
                w_pend_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = HOLD_M1;
                w_dout_nxt  = 8'h01 << din;
            end
`endif
        end

`ifdef DECODER8_QUEUE_EN
        // Codes accepted mid-pulse or mid-gap park in the pending slot.
        if (w_accept && (r_state != S_IDLE) && !w_term) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_code_nxt  = din;
        end
`endif
    end

    // State, counter, output and pending registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_dout  <= 8'h00;
`ifdef DECODER8_QUEUE_EN
            r_pend_valid <= 1'b0;
            r_pend_code  <= 3'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
`ifdef DECODER8_QUEUE_EN
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_code  <= w_pend_code_nxt;
`endif
        end
    end

    assign din_ready = w_ready;
    assign dout      = r_dout;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_decoder8_pulse.sv
// Bench for decoder8_pulse: three instances (HOLD/GAP = 4/1, 1/0, 2/1)
// driven from per-cycle vector tables and hand-written reset sequences.
module tb_decoder8_pulse;

  logic clk;
  logic rst_n;

  logic       a_en, a_v, a_rdy, a_busy;
  logic [2:0] a_d;
  logic [7:0] a_dout;
  logic [1:0] a_st;

  logic       b_en, b_v, b_rdy, b_busy;
  logic [2:0] b_d;
  logic [7:0] b_dout;
  logic [1:0] b_st;

  logic       c_en, c_v, c_rdy, c_busy;
  logic [2:0] c_d;
  logic [7:0] c_dout;
  logic [1:0] c_st;

  int n_pass;
  int n_total;

  typedef struct {
    logic       en;
    logic       v;
    logic [2:0] d;
    logic [7:0] exp_dout;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  logic [9:0] exp_q[$];

  vec_t tbl_a[22];
`ifdef DECODER8_QUEUE_EN
  vec_t tbl_c[16];
`else
  vec_t tbl_c[6];
`endif

  decoder8_pulse #(.HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .din_valid(a_v), .din(a_d),
    .din_ready(a_rdy), .dout(a_dout), .busy(a_busy), .dbg_state(a_st)
  );

  decoder8_pulse #(.HOLD(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .din_valid(b_v), .din(b_d),
    .din_ready(b_rdy), .dout(b_dout), .busy(b_busy), .dbg_state(b_st)
  );

  decoder8_pulse #(.HOLD(2), .GAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .din_valid(c_v), .din(c_d),
    .din_ready(c_rdy), .dout(c_dout), .busy(c_busy), .dbg_state(c_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic v, input logic [2:0] d,
                              input logic [7:0] o, input logic r, input logic b);
    vec_t t;
    t.en = en; t.v = v; t.d = d; t.exp_dout = o; t.exp_ready = r; t.exp_busy = b;
    return t;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // driver: one vector per cycle, inputs changed on the falling edge
  task automatic apply(input int sel, input vec_t t, input string tag);
    logic [9:0] e;
    logic [7:0] act_d;
    logic       act_r;
    logic       act_b;
    @(negedge clk);
    case (sel)
      0: begin a_en = t.en; a_v = t.v; a_d = t.d; end
      1: begin b_en = t.en; b_v = t.v; b_d = t.d; end
      default: begin c_en = t.en; c_v = t.v; c_d = t.d; end
    endcase
    exp_q.push_back({t.exp_dout, t.exp_ready, t.exp_busy});
    #1;
    case (sel)
      0: begin act_d = a_dout; act_r = a_rdy; act_b = a_busy; end
      1: begin act_d = b_dout; act_r = b_rdy; act_b = b_busy; end
      default: begin act_d = c_dout; act_r = c_rdy; act_b = c_busy; end
    endcase
    e = exp_q.pop_front();
    check({tag, " dout"}, act_d, e[9:2]);
    check({tag, " ready"}, {7'd0, act_r}, {7'd0, e[1]});
    check({tag, " busy"}, {7'd0, act_b}, {7'd0, e[0]});
  endtask

  task automatic idle_inputs();
    a_en = 1'b0; a_v = 1'b0; a_d = 3'd0;
    b_en = 1'b0; b_v = 1'b0; b_d = 3'd0;
    c_en = 1'b0; c_v = 1'b0; c_d = 3'd0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // dut_a: HOLD=4 GAP=1
    tbl_a[0]  = mk(1, 1, 3'd5, 8'h00, 1, 0);
    tbl_a[1]  = mk(1, 1, 3'd2, 8'h20, 0, 1);
    tbl_a[2]  = mk(1, 0, 3'd0, 8'h20, 0, 1);
    tbl_a[3]  = mk(1, 1, 3'd6, 8'h20, 0, 1);
    tbl_a[4]  = mk(1, 0, 3'd0, 8'h20, 0, 1);
    tbl_a[5]  = mk(1, 1, 3'd1, 8'h00, 0, 1);
    tbl_a[6]  = mk(1, 0, 3'd0, 8'h00, 1, 0);
    tbl_a[7]  = mk(0, 1, 3'd3, 8'h00, 0, 0);
    tbl_a[8]  = mk(1, 1, 3'd7, 8'h00, 1, 0);
    tbl_a[9]  = mk(1, 0, 3'd0, 8'h80, 0, 1);
    tbl_a[10] = mk(0, 1, 3'd3, 8'h80, 0, 1);
    tbl_a[11] = mk(0, 1, 3'd3, 8'h80, 0, 1);
    tbl_a[12] = mk(0, 1, 3'd3, 8'h80, 0, 1);
    tbl_a[13] = mk(0, 1, 3'd3, 8'h00, 0, 1);
    tbl_a[14] = mk(0, 1, 3'd3, 8'h00, 0, 0);
    tbl_a[15] = mk(1, 1, 3'd0, 8'h00, 1, 0);
    tbl_a[16] = mk(1, 1, 3'd4, 8'h01, 0, 1);
    tbl_a[17] = mk(1, 0, 3'd0, 8'h01, 0, 1);
    tbl_a[18] = mk(1, 0, 3'd0, 8'h01, 0, 1);
    tbl_a[19] = mk(1, 0, 3'd0, 8'h01, 0, 1);
    tbl_a[20] = mk(1, 0, 3'd0, 8'h00, 0, 1);
    tbl_a[21] = mk(1, 0, 3'd0, 8'h00, 1, 0);

`ifdef DECODER8_QUEUE_EN
    // dut_c: HOLD=2 GAP=1, pending slot chaining and terminal-edge accept
    tbl_c[0]  = mk(1, 1, 3'd2, 8'h00, 1, 0);
    tbl_c[1]  = mk(1, 1, 3'd6, 8'h04, 1, 1);
    tbl_c[2]  = mk(1, 1, 3'd1, 8'h04, 0, 1);
    tbl_c[3]  = mk(1, 0, 3'd0, 8'h00, 0, 1);
    tbl_c[4]  = mk(1, 0, 3'd0, 8'h40, 1, 1);
    tbl_c[5]  = mk(1, 0, 3'd0, 8'h40, 1, 1);
    tbl_c[6]  = mk(1, 0, 3'd0, 8'h00, 1, 1);
    tbl_c[7]  = mk(1, 0, 3'd0, 8'h00, 1, 0);
    tbl_c[8]  = mk(1, 1, 3'd3, 8'h00, 1, 0);
    tbl_c[9]  = mk(1, 0, 3'd0, 8'h08, 1, 1);
    tbl_c[10] = mk(1, 0, 3'd0, 8'h08, 1, 1);
    tbl_c[11] = mk(1, 1, 3'd5, 8'h00, 1, 1);
    tbl_c[12] = mk(1, 0, 3'd0, 8'h20, 1, 1);
    tbl_c[13] = mk(1, 0, 3'd0, 8'h20, 1, 1);
    tbl_c[14] = mk(1, 0, 3'd0, 8'h00, 1, 1);
    tbl_c[15] = mk(1, 0, 3'd0, 8'h00, 1, 0);
`else
    // dut_c: HOLD=2 GAP=1, valid held high -> accepts every HOLD+GAP+1 cycles
    tbl_c[0] = mk(1, 1, 3'd4, 8'h00, 1, 0);
    tbl_c[1] = mk(1, 1, 3'd4, 8'h10, 0, 1);
    tbl_c[2] = mk(1, 1, 3'd4, 8'h10, 0, 1);
    tbl_c[3] = mk(1, 1, 3'd4, 8'h00, 0, 1);
    tbl_c[4] = mk(1, 1, 3'd4, 8'h00, 1, 0);
    tbl_c[5] = mk(1, 0, 3'd0, 8'h10, 0, 1);
`endif

    // reset held through an edge with a code offered: nothing accepted
    rst_n = 1'b0;
    idle_inputs();
    a_en = 1'b1; a_v = 1'b1; a_d = 3'd5;
    @(posedge clk);
    #1;
    check("rst a dout", a_dout, 8'h00);
    check("rst a busy", {7'd0, a_busy}, 8'h00);
    check("rst b dout", b_dout, 8'h00);
    check("rst c busy", {7'd0, c_busy}, 8'h00);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    check("post-rst a busy", {7'd0, a_busy}, 8'h00);

    for (int i = 0; i < $size(tbl_a); i++)
      apply(0, tbl_a[i], $sformatf("tblA[%0d]", i));

`ifndef DECODER8_QUEUE_EN
    // HOLD=1 GAP=0, valid held high, din advances after each accept
    for (int k = 0; k < 12; k++) begin
      vec_t t;
      t.en = 1'b1;
      t.v  = 1'b1;
      t.d  = 3'(k / 2);
      t.exp_dout  = (k % 2 == 1) ? 8'(1 << ((k - 1) / 2)) : 8'h00;
      t.exp_ready = (k % 2 == 0);
      t.exp_busy  = (k % 2 == 1);
      apply(1, t, $sformatf("seqB[%0d]", k));
    end
    @(negedge clk);
    b_v = 1'b0;
`endif

    for (int i = 0; i < $size(tbl_c); i++)
      apply(2, tbl_c[i], $sformatf("tblC[%0d]", i));
    @(negedge clk);
    c_v = 1'b0;
    repeat (6) @(negedge clk);

    // asynchronous reset in the middle of a pulse
    apply(0, mk(1, 1, 3'd3, 8'h00, 1, 0), "mid-rst accept");
    apply(0, mk(1, 0, 3'd0, 8'h08, 0, 1), "mid-rst pulse");
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst dout", a_dout, 8'h00);
    check("async rst busy", {7'd0, a_busy}, 8'h00);
    check("async rst ready", {7'd0, a_rdy}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    a_en = 1'b0;
    #1;
    check("release ready en0", {7'd0, a_rdy}, 8'h00);
    a_en = 1'b1;
    #1;
    check("release ready en1", {7'd0, a_rdy}, 8'h01);
    apply(0, mk(1, 1, 3'd6, 8'h00, 1, 0), "post-rst accept");
    apply(0, mk(1, 0, 3'd0, 8'h40, 0, 1), "post-rst pulse");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
